// File: rtl/game_state_ctrl_if.sv
// Bundle between the game sequencer, the ball engine and the renderer.
// master: ball-engine side (drives keycode/Blocks/lives); slave: game_state_ctrl.
interface game_state_ctrl_if;
    logic [7:0]  keycode;
    logic [31:0] Blocks;
    logic [1:0]  lives;
    logic [32:0] Block_Array;
    logic        Game_Reset;
    logic        start_menu;
    logic [13:0] score;
    logic [1:0]  level;
    logic        win;
    logic        game_over;

    modport master (
        output keycode, Blocks, lives,
        input  Block_Array, Game_Reset, start_menu,
        input  score, level, win, game_over
    );

    modport slave (
        input  keycode, Blocks, lives,
        output Block_Array, Game_Reset, start_menu,
        output score, level, win, game_over
    );
endinterface

// File: rtl/game_state_ctrl.sv
// Game sequencer: menu/load/play/win/over flow, scoring and level patterns.
// Ports: frame_clk, Reset_n (async, active-low), bus (game_state_ctrl_if.slave).
module game_state_ctrl #(
    parameter logic [7:0]  KEY_START    = 8'h28,
    parameter logic [7:0]  KEY_MENU     = 8'h29,
    parameter int          POINTS       = 10,
    parameter int          SCORE_MAX    = 9999,
    parameter int          RESET_FRAMES = 2,
    parameter logic [31:0] LVL0_PAT     = 32'hFFFFFFFF,
    parameter logic [31:0] LVL1_PAT     = 32'hAAAA5555,
    parameter logic [31:0] LVL2_PAT     = 32'hF0F00F0F,
    parameter logic [31:0] LVL3_PAT     = 32'hFFFFFFFF
) (
    input logic              frame_clk,
    input logic              Reset_n,
    game_state_ctrl_if.slave bus
);
    localparam int CW = (RESET_FRAMES > 1) ? $clog2(RESET_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RESET_FRAMES - 1);

    typedef enum logic [2:0] {
        MENU, LOAD, PLAY, WIN, OVER
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [31:0]   prev_blocks, prev_nxt;
    logic [31:0]   arr, arr_nxt;
    logic          first_play, first_nxt;
    logic          start_prev, menu_prev;
    logic [13:0]   score, score_nxt;
    logic [1:0]    level, level_nxt;
    logic          win, win_nxt;
    logic          over, over_nxt;
    logic          game_reset, start_menu;
    logic          start_hit, menu_hit;
    logic          start_press, menu_press;
    logic [5:0]    drop_cnt;
    logic [19:0]   sum;
    logic [13:0]   score_sat;

    function automatic logic [31:0] pat(input logic [1:0] l);
        case (l)
            2'd0:    pat = LVL0_PAT;
            2'd1:    pat = LVL1_PAT;
            2'd2:    pat = LVL2_PAT;
            default: pat = LVL3_PAT;
        endcase
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    // A press is the first edge on which the key is seen; holding it
    // down does not repeat.
    always_comb begin
        start_hit   = (bus.keycode == KEY_START);
        menu_hit    = (bus.keycode == KEY_MENU);
        start_press = start_hit && !start_prev;
        menu_press  = menu_hit && !menu_prev;
    end

    // 20-bit sum leaves headroom so saturation never sees a wrapped value.
    always_comb begin
        drop_cnt  = popcount(prev_blocks & ~bus.Blocks);
        sum       = {6'd0, score} + 20'(POINTS) * {14'd0, drop_cnt};
        score_sat = (sum > 20'(SCORE_MAX)) ? 14'(SCORE_MAX) : sum[13:0];
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        prev_nxt  = prev_blocks;
        arr_nxt   = arr;
        first_nxt = first_play;
        score_nxt = score;
        level_nxt = level;
        win_nxt   = win;
        over_nxt  = over;
        case (state)
            MENU: begin
                if (start_press) begin
                    state_nxt = LOAD;
                    score_nxt = '0;
                    level_nxt = '0;
                end
            end
            LOAD: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = PLAY;
                    cnt_nxt   = '0;
                    prev_nxt  = pat(level);
                    first_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PLAY: begin
                // The first PLAY edge only resynchronises prev_blocks
                // to what the freshly reset ball engine reports.
                if (!first_play) score_nxt = score_sat;
                first_nxt = 1'b0;
                prev_nxt  = bus.Blocks;
                if (menu_press) begin
                    state_nxt = MENU;
                    win_nxt   = 1'b0;
                    over_nxt  = 1'b0;
                end else if (bus.lives == 2'd0) begin
                    state_nxt = OVER;
                    over_nxt  = 1'b1;
                end else if (bus.Blocks == 32'd0) begin
                    state_nxt = WIN;
                    win_nxt   = 1'b1;
                end
            end
            WIN: begin
                if (start_press) begin
                    state_nxt = LOAD;
                    level_nxt = level + 2'd1;
                    win_nxt   = 1'b0;
                end else if (menu_press) begin
                    state_nxt = MENU;
                    win_nxt   = 1'b0;
                end
            end
            OVER: begin
                if (start_press || menu_press) begin
                    state_nxt = MENU;
                    over_nxt  = 1'b0;
                end
            end
            default: state_nxt = MENU;
        endcase
        // Pattern latched once on LOAD entry, using the level being entered.
        if (state_nxt == LOAD && state != LOAD) arr_nxt = pat(level_nxt);
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= MENU;
            cnt         <= '0;
            prev_blocks <= LVL0_PAT;
            arr         <= LVL0_PAT;
            first_play  <= 1'b0;
            start_prev  <= 1'b0;
            menu_prev   <= 1'b0;
            score       <= '0;
            level       <= '0;
            win         <= 1'b0;
            over        <= 1'b0;
            game_reset  <= 1'b1;
            start_menu  <= 1'b1;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            prev_blocks <= prev_nxt;
            arr         <= arr_nxt;
            first_play  <= first_nxt;
            start_prev  <= start_hit;
            menu_prev   <= menu_hit;
            score       <= score_nxt;
            level       <= level_nxt;
            win         <= win_nxt;
            over        <= over_nxt;
            game_reset  <= (state_nxt == MENU) || (state_nxt == LOAD);
            start_menu  <= (state_nxt == MENU);
        end
    end

    assign bus.Block_Array = {1'b0, arr};
    assign bus.Game_Reset  = game_reset;
    assign bus.start_menu  = start_menu;
    assign bus.score       = score;
    assign bus.level       = level;
    assign bus.win         = win;
    assign bus.game_over   = over;
endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl: random/directed frames checked
// against a rule-level game model; monitor compares on falling edges.
module tb_game_state_ctrl;
    localparam int RF = 2;

    logic frame_clk = 1'b0;
    logic Reset_n;

    game_state_ctrl_if ifc();

    game_state_ctrl dut (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .bus       (ifc)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        logic [32:0] arr;
        logic        gr;
        logic        sm;
        logic [13:0] score;
        logic [1:0]  level;
        logic        win;
        logic        over;
        int          frame;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    int   frame = 0;

    typedef enum {M_MENU, M_LOAD, M_PLAY, M_WIN, M_OVER} mode_t;
    mode_t       m_mode;
    int          m_score, m_level, m_load_left;
    bit          m_win, m_over, m_armed, m_ks, m_km;
    logic [31:0] m_arr, m_prev;

    function automatic logic [31:0] pat_of(int l);
        case (l)
            0:       return 32'hFFFFFFFF;
            1:       return 32'hAAAA5555;
            2:       return 32'hF0F00F0F;
            default: return 32'hFFFFFFFF;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = M_MENU;
        m_score = 0;
        m_level = 0;
        m_load_left = 0;
        m_win = 0;
        m_over = 0;
        m_armed = 0;
        m_ks = 0;
        m_km = 0;
        m_arr = pat_of(0);
        m_prev = pat_of(0);
    endtask

    task automatic model_step(logic [7:0] k, logic [31:0] b, logic [1:0] l);
        bit sp, mp;
        int s;
        sp = (k == 8'h28) && !m_ks;
        mp = (k == 8'h29) && !m_km;
        m_ks = (k == 8'h28);
        m_km = (k == 8'h29);
        case (m_mode)
            M_MENU: if (sp) begin
                m_mode = M_LOAD;
                m_score = 0;
                m_level = 0;
                m_arr = pat_of(0);
                m_load_left = RF;
            end
            M_LOAD: begin
                m_load_left--;
                if (m_load_left == 0) begin
                    m_mode = M_PLAY;
                    m_prev = pat_of(m_level);
                    m_armed = 0;
                end
            end
            M_PLAY: begin
                if (m_armed) begin
                    s = m_score + 10 * $countones(m_prev & ~b);
                    m_score = (s > 9999) ? 9999 : s;
                end
                m_armed = 1;
                m_prev = b;
                if (mp) begin
                    m_mode = M_MENU;
                    m_win = 0;
                    m_over = 0;
                end else if (l == 0) begin
                    m_mode = M_OVER;
                    m_over = 1;
                end else if (b == 0) begin
                    m_mode = M_WIN;
                    m_win = 1;
                end
            end
            M_WIN: if (sp) begin
                m_level = (m_level + 1) % 4;
                m_win = 0;
                m_mode = M_LOAD;
                m_arr = pat_of(m_level);
                m_load_left = RF;
            end else if (mp) begin
                m_mode = M_MENU;
                m_win = 0;
            end
            M_OVER: if (sp || mp) begin
                m_mode = M_MENU;
                m_over = 0;
            end
            default: m_mode = M_MENU;
        endcase
    endtask

    task automatic push_exp();
        exp_t x;
        x.arr = {1'b0, m_arr};
        x.gr = (m_mode == M_MENU) || (m_mode == M_LOAD);
        x.sm = (m_mode == M_MENU);
        x.score = 14'(m_score);
        x.level = 2'(m_level);
        x.win = m_win;
        x.over = m_over;
        x.frame = frame;
        sb.push_back(x);
    endtask

    task automatic step(logic [7:0] k, logic [31:0] b, logic [1:0] l);
        @(negedge frame_clk);
        #1;
        Reset_n = 1'b1;
        ifc.keycode = k;
        ifc.Blocks = b;
        ifc.lives = l;
        frame++;
        model_step(k, b, l);
        push_exp();
        @(posedge frame_clk);
    endtask

    task automatic reset_pulse();
        @(negedge frame_clk);
        #1;
        Reset_n = 1'b0;
        frame++;
        model_reset();
        push_exp();
        @(posedge frame_clk);
    endtask

    task automatic chk(string n, logic [32:0] got, logic [32:0] exp, int f);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s frame=%0d got=%h exp=%h", n, f, got, exp);
        end
    endtask

    always @(negedge frame_clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("Block_Array", ifc.Block_Array, e.arr, e.frame);
            chk("Game_Reset", 33'(ifc.Game_Reset), 33'(e.gr), e.frame);
            chk("start_menu", 33'(ifc.start_menu), 33'(e.sm), e.frame);
            chk("score", 33'(ifc.score), 33'(e.score), e.frame);
            chk("level", 33'(ifc.level), 33'(e.level), e.frame);
            chk("win", 33'(ifc.win), 33'(e.win), e.frame);
            chk("game_over", 33'(ifc.game_over), 33'(e.over), e.frame);
        end
    end

    logic [31:0] b;
    logic [7:0]  k;
    logic [1:0]  lv;
    int          hold;
    int          r;

    initial begin
        Reset_n = 1'b0;
        ifc.keycode = 8'h00;
        ifc.Blocks = '1;
        ifc.lives = 2'd3;
        model_reset();

        // reset state, then idle in MENU
        reset_pulse();
        step(8'h00, '1, 3);

        // held Enter starts exactly one game
        repeat (5) step(8'h28, '1, 3);

        // multi-block drop, then last drop together with the win
        step(8'h00, 32'hFFFFFFF0, 3);
        step(8'h00, 32'hFF00FFF0, 3);
        step(8'h00, 32'h00000000, 3);
        step(8'h00, 32'h00000000, 3);

        // next level, then lose the last life and escape to menu
        step(8'h28, '1, 3);
        for (int i = 0; i < 10 && m_mode != M_PLAY; i++) step(8'h00, '1, 3);
        step(8'h00, 32'h7FFFFFFF, 1);
        step(8'h00, 32'h7FFFFFFE, 0);
        step(8'h29, 32'h7FFFFFFE, 0);
        step(8'h00, '1, 3);

        // long unbroken run: saturation and level wrap
        for (int lvl = 0; lvl < 45; lvl++) begin
            step(8'h00, '1, 3);
            step(8'h28, '1, 3);
            for (int i = 0; i < 10 && m_mode != M_PLAY; i++) begin
                step(8'h00, '1, 3);
            end
            b = '1;
            for (int i = 0; i < 20 && m_mode == M_PLAY; i++) begin
                if (m_armed) b = (i > 8) ? 32'd0 : (b & $urandom());
                step(8'h00, b, 3);
            end
        end

        // reset in the middle of LOAD
        step(8'h00, '1, 3);
        step(8'h28, '1, 3);
        reset_pulse();
        step(8'h00, '1, 3);

        // random play
        hold = 0;
        k = 8'h00;
        b = '1;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                r = $urandom_range(0, 99);
                if (r < 70) k = 8'h00;
                else if (r < 85) k = 8'h28;
                else if (r < 92) k = 8'h29;
                else k = 8'($urandom());
                hold = $urandom_range(1, 3);
            end
            hold--;
            r = $urandom_range(0, 99);
            if (m_mode == M_LOAD) b = '1;
            else if (r < 55) b = b;
            else if (r < 85) b = b & ($urandom() | $urandom());
            else if (r < 92) b = b | (32'd1 << $urandom_range(0, 31));
            else if (r < 95) b = 32'd0;
            else b = '1;
            lv = ($urandom_range(0, 99) < 3) ? 2'd0 : 2'd3;
            if (i % 500 == 250) reset_pulse();
            step(k, b, lv);
        end

        @(negedge frame_clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
